// File: rtl/hdd_pkg.sv
// hdd_pkg: shared widths, FSM state codes and helpers for the
// slot-7 HDD image server.
package hdd_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int IDX_W        = 9;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [2:0]       state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD_REQ   = 3'd1;
    localparam state_t ST_RD_ZERO  = 3'd2;
    localparam state_t ST_WR_FETCH = 3'd3;
    localparam state_t ST_WR_REQ   = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    // Last legal block is nsect-1; nothing is legal while unmounted.
    function automatic logic sector_ok(
        input logic        mounted,
        input logic [31:0] sector,
        input logic [31:0] nsect
    );
        return mounted && (sector < nsect);
    endfunction

endpackage

// File: rtl/hdd_sector_counter.sv
// hdd_sector_counter: byte index within the current 512-byte block
// plus a flag marking the final byte.
import hdd_pkg::*;

module hdd_sector_counter (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output idx_t idx,
    output logic last
);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = &idx;

endmodule

// File: rtl/hdd_image_server.sv
// hdd_image_server: slot-7 HDD sector-port responder moving 512-byte
// blocks between the card buffer and the byte-wide image store.
import hdd_pkg::*;

module hdd_image_server #(
    parameter int MEM_AW = 25,
    parameter int SEC_W  = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [SEC_W-1:0]  hdd_sector,
    input  logic              hdd_read,
    input  logic              hdd_write,
    output logic              hdd_mounted,
    output logic              hdd_protect,
    output logic [IDX_W-1:0]  ram_addr,
    output logic [7:0]        ram_di,
    input  logic [7:0]        ram_do,
    output logic              ram_we,
    input  logic              img_mount,
    input  logic [MEM_AW-1:0] img_size,
    input  logic              img_ro,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NS_W = MEM_AW - IDX_W;

    state_t            state;
    logic [SEC_W-1:0]  sector_q;
    logic [NS_W-1:0]   nsect;
    logic              err_q;
    logic              cap_q;
    logic [7:0]        wdata_q;
    logic              pend_q;
    logic              pend_ro;
    logic [MEM_AW-1:0] pend_size;
    logic [MEM_AW-1:0] base;
    idx_t              idx;
    logic              last;
    logic              idx_clr;
    logic              idx_inc;
    logic              in_rng;
    logic              rd_ack;
    logic              wr_ack;

    assign in_rng = sector_ok(hdd_mounted, 32'(hdd_sector), 32'(nsect));
    assign base   = MEM_AW'({sector_q, 9'b0});
    assign rd_ack = (state == ST_RD_REQ) && mem_ack;
    assign wr_ack = (state == ST_WR_REQ) && mem_ack;

    assign idx_clr = (state == ST_IDLE);
    assign idx_inc = rd_ack || wr_ack || (state == ST_RD_ZERO);

    hdd_sector_counter u_cnt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (idx_clr),
        .inc     (idx_inc),
        .idx     (idx),
        .last    (last)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            sector_q <= '0;
            err_q    <= 1'b0;
            cap_q    <= 1'b0;
            wdata_q  <= 8'h00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (hdd_read) begin
                        sector_q <= hdd_sector;
                        err_q    <= !in_rng;
                        state    <= in_rng ? ST_RD_REQ : ST_RD_ZERO;
                    end else if (hdd_write) begin
                        sector_q <= hdd_sector;
                        if (in_rng && !hdd_protect) begin
                            state <= ST_WR_FETCH;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (rd_ack && last) state <= ST_DONE;
                end
                ST_RD_ZERO: begin
                    if (last) state <= ST_DONE;
                end
                ST_WR_FETCH: begin
                    cap_q <= 1'b1;
                    state <= ST_WR_REQ;
                end
                ST_WR_REQ: begin
                    // ram_do is valid only in the first WR_REQ cycle.
                    if (cap_q) begin
                        wdata_q <= ram_do;
                        cap_q   <= 1'b0;
                    end
                    if (wr_ack) state <= last ? ST_DONE : ST_WR_FETCH;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Mount strobes outside IDLE wait here until the transfer ends.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hdd_mounted <= 1'b0;
            hdd_protect <= 1'b0;
            nsect       <= '0;
            pend_q      <= 1'b0;
            pend_ro     <= 1'b0;
            pend_size   <= '0;
        end else if (state == ST_IDLE) begin
            if (img_mount) begin
                hdd_mounted <= |img_size;
                hdd_protect <= img_ro;
                nsect       <= img_size[MEM_AW-1:IDX_W];
                pend_q      <= 1'b0;
            end else if (pend_q) begin
                hdd_mounted <= |pend_size;
                hdd_protect <= pend_ro;
                nsect       <= pend_size[MEM_AW-1:IDX_W];
                pend_q      <= 1'b0;
            end
        end else if (img_mount) begin
            pend_q    <= 1'b1;
            pend_size <= img_size;
            pend_ro   <= img_ro;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign mem_req   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign mem_we    = (state == ST_WR_REQ);
    assign mem_addr  = mem_req ? base + MEM_AW'(idx) : '0;
    assign mem_wdata = mem_we ? (cap_q ? ram_do : wdata_q) : 8'h00;
    assign ram_addr  = idx;
    assign ram_we    = rd_ack || (state == ST_RD_ZERO);
    assign ram_di    = rd_ack ? mem_rdata : 8'h00;
    assign done      = (state == ST_DONE);
    assign err       = done && err_q;

endmodule

// File: tb/tb_hdd_image_server.sv
// tb_hdd_image_server: randomized scenarios against a card-buffer model,
// an image-store responder and a block-level reference model.
module tb_hdd_image_server;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hdd_sector = '0;
    logic        hdd_read = 1'b0;
    logic        hdd_write = 1'b0;
    logic        hdd_mounted;
    logic        hdd_protect;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do = '0;
    logic        ram_we;
    logic        img_mount = 1'b0;
    logic [24:0] img_size = '0;
    logic        img_ro = 1'b0;
    logic [24:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk_sys = ~clk_sys;

    hdd_image_server dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .hdd_sector  (hdd_sector),
        .hdd_read    (hdd_read),
        .hdd_write   (hdd_write),
        .hdd_mounted (hdd_mounted),
        .hdd_protect (hdd_protect),
        .ram_addr    (ram_addr),
        .ram_di      (ram_di),
        .ram_do      (ram_do),
        .ram_we      (ram_we),
        .img_mount   (img_mount),
        .img_size    (img_size),
        .img_ro      (img_ro),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int ram_we_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int req_cyc = 0;
    logic [7:0] bufm [512];
    logic [7:0] pre [512];
    logic tb_load = 1'b0;

    logic [7:0]  img [1 << 20];
    logic [24:0] alog [4096];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int acc_cnt = 0;
    int lat = 1;

    int mdl_size = 0;
    bit mdl_ro = 1'b0;

    // Card sector buffer: synchronous RAM, read data one clock after address.
    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (tb_load) begin
            for (int k = 0; k < 512; k++) bufm[k] <= pre[k];
        end else if (ram_we) begin
            bufm[ram_addr] <= ram_di;
        end
        if (ram_we) ram_we_cnt <= ram_we_cnt + 1;
        ram_do <= bufm[ram_addr];
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (done && err) err_cnt <= err_cnt + 1;
        if (mem_req) req_cyc <= req_cyc + 1;
    end

    // Image store: acks each request after lat clocks, one-cycle ack.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        for (int k = 0; k < (1 << 20); k++) img[k] = 8'($urandom);
        forever begin
            @(negedge clk_sys);
            if (reset || mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_req) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    mem_ack = 1'b1;
                    alog[acc_cnt % 4096] = mem_addr;
                    acc_cnt++;
                    if (mem_we) begin
                        img[mem_addr[19:0]] = mem_wdata;
                        wr_cnt++;
                    end else begin
                        mem_rdata = img[mem_addr[19:0]];
                        rd_cnt++;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    function automatic bit mdl_in_range(input int sec);
        return (mdl_size != 0) && (sec < mdl_size / 512);
    endfunction

    task automatic pulse_strobe(input bit rd, input bit wr, input int sec,
                                output int t0);
        @(negedge clk_sys);
        hdd_sector = 16'(sec);
        hdd_read = rd;
        hdd_write = wr;
        t0 = cyc;
        @(negedge clk_sys);
        hdd_read = 1'b0;
        hdd_write = 1'b0;
    endtask

    task automatic do_mount(input int size, input bit ro);
        @(negedge clk_sys);
        img_mount = 1'b1;
        img_size = 25'(size);
        img_ro = ro;
        @(negedge clk_sys);
        img_mount = 1'b0;
        mdl_size = size;
        mdl_ro = ro;
    endtask

    task automatic load_buf();
        for (int k = 0; k < 512; k++) pre[k] = 8'($urandom_range(1, 255));
        @(negedge clk_sys);
        tb_load = 1'b1;
        @(negedge clk_sys);
        tb_load = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit timed_out);
        timed_out = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk_sys);
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_sys);
        total++;
        if ({busy, mem_req, mem_we, ram_we, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {busy, mem_req, mem_we, ram_we, done, err});
        end
        total++;
        if ({hdd_mounted, hdd_protect} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mount got=%b want=00",
                     {hdd_mounted, hdd_protect});
        end
        total++;
        if (mem_addr !== 25'd0 || ram_addr !== 9'd0 || ram_di !== 8'd0 ||
            mem_wdata !== 8'd0) begin
            bad++;
            $display("FAIL reset_bus got mem_addr=%h ram_addr=%h want 0",
                     mem_addr, ram_addr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        total++;
        if (busy !== 1'b0 || done_cnt !== 0) begin
            bad++;
            $display("FAIL reset_release busy=%b done_cnt=%0d want 0/0",
                     busy, done_cnt);
        end
    endtask

    task automatic test_read(input int sec, input int l);
        int we0, d0, e0, a0, w0, t0, nb, na;
        bit to, ok;
        logic [7:0] ev;
        ok = mdl_in_range(sec);
        lat = l;
        load_buf();
        we0 = ram_we_cnt; d0 = done_cnt; e0 = err_cnt;
        a0 = acc_cnt; w0 = wr_cnt;
        pulse_strobe(1'b1, 1'b0, sec, t0);
        wait_done(d0, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL read_timeout sec=%0d got no done want done", sec);
        end
        repeat (3) @(negedge clk_sys);
        total++;
        if (ram_we_cnt - we0 !== 512) begin
            bad++;
            $display("FAIL read_we_count sec=%0d got=%0d want=512",
                     sec, ram_we_cnt - we0);
        end
        total++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== (ok ? 0 : 1)) begin
            bad++;
            $display("FAIL read_done sec=%0d got done=%0d err=%0d want 1/%0d",
                     sec, done_cnt - d0, err_cnt - e0, ok ? 0 : 1);
        end
        total++;
        if (acc_cnt - a0 !== (ok ? 512 : 0) || wr_cnt !== w0) begin
            bad++;
            $display("FAIL read_mem_count sec=%0d got=%0d wr=%0d want=%0d/0",
                     sec, acc_cnt - a0, wr_cnt - w0, ok ? 512 : 0);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL read_busy_after got=%b want=0", busy);
        end
        nb = 0;
        for (int k = 0; k < 512; k++) begin
            ev = ok ? img[sec * 512 + k] : 8'h00;
            if (bufm[k] !== ev) begin
                if (nb == 0)
                    $display("FAIL read_data sec=%0d byte=%0d got=%h want=%h",
                             sec, k, bufm[k], ev);
                nb++;
            end
        end
        total++;
        if (nb != 0) bad++;
        if (ok) begin
            na = 0;
            for (int k = 0; k < 512; k++)
                if (alog[(a0 + k) % 4096] !== 25'(sec * 512 + k)) na++;
            total++;
            if (na != 0) begin
                bad++;
                $display("FAIL read_addr sec=%0d got %0d bad addrs want 0",
                         sec, na);
            end
        end
    endtask

    task automatic test_write(input int sec, input int l);
        int d0, e0, a0, w0, r0, q0, t0, nb, na;
        bit to, ok;
        logic [7:0] expb [512];
        ok = mdl_in_range(sec) && !mdl_ro;
        lat = l;
        load_buf();
        for (int k = 0; k < 512; k++) expb[k] = pre[k];
        d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
        w0 = wr_cnt; r0 = rd_cnt; q0 = req_cyc;
        pulse_strobe(1'b0, 1'b1, sec, t0);
        wait_done(d0, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL write_timeout sec=%0d got no done want done", sec);
        end
        repeat (3) @(negedge clk_sys);
        total++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== (ok ? 0 : 1)) begin
            bad++;
            $display("FAIL write_done sec=%0d got done=%0d err=%0d want 1/%0d",
                     sec, done_cnt - d0, err_cnt - e0, ok ? 0 : 1);
        end
        total++;
        if (wr_cnt - w0 !== (ok ? 512 : 0) || rd_cnt !== r0) begin
            bad++;
            $display("FAIL write_count sec=%0d got wr=%0d rd=%0d want %0d/0",
                     sec, wr_cnt - w0, rd_cnt - r0, ok ? 512 : 0);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL write_busy_after got=%b want=0", busy);
        end
        if (ok) begin
            nb = 0;
            na = 0;
            for (int k = 0; k < 512; k++) begin
                if (img[sec * 512 + k] !== expb[k]) begin
                    if (nb == 0)
                        $display("FAIL write_data sec=%0d byte=%0d got=%h want=%h",
                                 sec, k, img[sec * 512 + k], expb[k]);
                    nb++;
                end
                if (alog[(a0 + k) % 4096] !== 25'(sec * 512 + k)) na++;
            end
            total++;
            if (nb != 0) bad++;
            total++;
            if (na != 0) begin
                bad++;
                $display("FAIL write_addr sec=%0d got %0d bad addrs want 0",
                         sec, na);
            end
        end else begin
            total++;
            if (req_cyc !== q0) begin
                bad++;
                $display("FAIL reject_no_req got=%0d req cycles want=0",
                         req_cyc - q0);
            end
            total++;
            if (done_cyc !== t0 + 1) begin
                bad++;
                $display("FAIL reject_latency got=%0d want=%0d",
                         done_cyc - t0, 1);
            end
        end
    endtask

    task automatic test_both_strobes();
        int d0, e0, r0, w0, t0, nb;
        bit to;
        lat = 1;
        load_buf();
        d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt; w0 = wr_cnt;
        pulse_strobe(1'b1, 1'b1, 4, t0);
        wait_done(d0, to);
        repeat (3) @(negedge clk_sys);
        total++;
        if (to || rd_cnt - r0 !== 512 || wr_cnt !== w0) begin
            bad++;
            $display("FAIL both_strobes got rd=%0d wr=%0d want 512/0",
                     rd_cnt - r0, wr_cnt - w0);
        end
        nb = 0;
        for (int k = 0; k < 512; k++)
            if (bufm[k] !== img[4 * 512 + k]) nb++;
        total++;
        if (nb != 0 || err_cnt !== e0 || done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL both_data got %0d bad bytes err=%0d want 0/0",
                     nb, err_cnt - e0);
        end
    endtask

    task automatic test_busy_strobe();
        int d0, r0, w0, t0, nb;
        bit to;
        lat = 1;
        load_buf();
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
        pulse_strobe(1'b1, 1'b0, 7, t0);
        repeat (50) @(negedge clk_sys);
        pulse_strobe(1'b1, 1'b1, 10, t0);
        wait_done(d0, to);
        repeat (20) @(negedge clk_sys);
        total++;
        if (to || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_strobe got done=%0d busy=%b want 1/0",
                     done_cnt - d0, busy);
        end
        nb = 0;
        for (int k = 0; k < 512; k++)
            if (bufm[k] !== img[7 * 512 + k]) nb++;
        total++;
        if (nb != 0 || rd_cnt - r0 !== 512 || wr_cnt !== w0) begin
            bad++;
            $display("FAIL busy_strobe_data got bad=%0d rd=%0d want 0/512",
                     nb, rd_cnt - r0);
        end
    endtask

    task automatic test_mount_mid();
        int d0, t0;
        bit to;
        lat = 1;
        d0 = done_cnt;
        pulse_strobe(1'b1, 1'b0, 1, t0);
        repeat (20) @(negedge clk_sys);
        img_mount = 1'b1;
        img_size = 25'd0;
        img_ro = 1'b1;
        @(negedge clk_sys);
        img_mount = 1'b0;
        repeat (5) @(negedge clk_sys);
        total++;
        if ({busy, hdd_mounted, hdd_protect} !== 3'b110) begin
            bad++;
            $display("FAIL mount_mid_busy got=%b want=110",
                     {busy, hdd_mounted, hdd_protect});
        end
        wait_done(d0, to);
        total++;
        if (to || hdd_mounted !== 1'b1) begin
            bad++;
            $display("FAIL mount_mid_at_done got=%b want=1", hdd_mounted);
        end
        repeat (2) @(negedge clk_sys);
        total++;
        if ({hdd_mounted, hdd_protect} !== 2'b01) begin
            bad++;
            $display("FAIL mount_mid_after got=%b want=01",
                     {hdd_mounted, hdd_protect});
        end
        mdl_size = 0;
        mdl_ro = 1'b1;
    endtask

    task automatic test_reset_mid();
        int we0, d0, t0, n;
        lat = 1;
        we0 = ram_we_cnt;
        d0 = done_cnt;
        pulse_strobe(1'b1, 1'b0, 3, t0);
        n = 0;
        while (ram_we_cnt - we0 < 100 && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL reset_mid_progress got=%0d bytes want>=100",
                     ram_we_cnt - we0);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({mem_req, busy, ram_we, done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_mid_abort got=%b want=0000",
                     {mem_req, busy, ram_we, done});
        end
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        total++;
        if (done_cnt !== d0 || busy !== 1'b0 || hdd_mounted !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after got done=%0d busy=%b mnt=%b want 0/0/0",
                     done_cnt - d0, busy, hdd_mounted);
        end
        mdl_size = 0;
        mdl_ro = 1'b0;
    endtask

    task automatic test_random();
        int sec, l, last_wr;
        last_wr = 9;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 5) == 0) sec = $urandom_range(2048, 65535);
            else sec = $urandom_range(0, 2047);
            l = $urandom_range(1, 2);
            if ($urandom_range(0, 1) == 1) begin
                test_write(sec, l);
                if (sec < 2048) last_wr = sec;
            end else begin
                test_read(sec, l);
            end
        end
        test_read(last_wr, 1);
    endtask

    initial begin
        test_reset();
        do_mount(1 << 20, 1'b0);
        test_read(3, 2);
        test_write(5, 1);
        test_read(5, 1);
        do_mount(1 << 20, 1'b1);
        test_write(0, 1);
        do_mount(1 << 20, 1'b0);
        test_read(2048, 1);
        test_read(2047, 1);
        test_both_strobes();
        test_busy_strobe();
        test_mount_mid();
        test_write(0, 1);
        test_read(0, 1);
        do_mount(1 << 20, 1'b0);
        test_reset_mid();
        do_mount(1 << 20, 1'b0);
        test_read(3, 2);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
